// File: rtl/pipe_share_arb.sv
// Round-robin arbiter feeding a shared, stall-free LAT-stage pipeline with flush/drain control.
// Optional per-requester saturating grant counters are built when PIPE_SHARE_ARB_STATS_EN is defined.
module pipe_share_arb #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int LAT   = 3,
  parameter int CNT_W = 16,
  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int IF_W = $clog2(LAT + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]       req_ready,
  input  logic                   flush,
  output logic [WIDTH-1:0]       o_data,
  output logic                   o_valid,
  output logic [ID_W-1:0]        o_id,
`ifdef PIPE_SHARE_ARB_STATS_EN
  input  logic [ID_W-1:0]        stat_sel,
  output logic [CNT_W-1:0]       stat_count,
`endif
  output logic                   busy
);

  // state | meaning
  // IDLE  | nothing offered, grants still allowed
  // RUN   | words being accepted or in flight
  // DRAIN | flush seen; no grants, pipeline empties
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  state_t                        state_q, state_d;
  logic [ID_W-1:0]               ptr_q, ptr_d;
  logic [IF_W-1:0]               inf_q, inf_d;
  logic [LAT-1:0]                vld_q;
  logic [LAT-1:0][WIDTH-1:0]     data_q;
  logic [LAT-1:0][ID_W-1:0]      id_q;

  logic                          grant_en;
  logic                          found;
  logic [ID_W-1:0]               gnt_idx;
  logic                          hs;
  logic                          word_exit;
  logic [WIDTH-1:0]              in_data;

  assign grant_en  = !flush && (state_q != DRAIN);
  assign word_exit = vld_q[LAT-1];

  // First valid requester at or after ptr, wrapping.
  always_comb begin
    int idx;
    found   = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && req_valid[idx]) begin
        found   = 1'b1;
        gnt_idx = ID_W'(idx);
      end
    end
  end

  assign hs        = grant_en && found;
  assign req_ready = hs ? (N_REQ'(1) << gnt_idx) : '0;
  assign in_data   = hs ? req_data[gnt_idx*WIDTH +: WIDTH] : '0;

  always_comb begin
    ptr_d = ptr_q;
    if (hs) begin
      if (gnt_idx == ID_W'(N_REQ - 1)) ptr_d = '0;
      else                             ptr_d = gnt_idx + ID_W'(1);
    end
  end

  always_comb begin
    inf_d = inf_q + IF_W'(hs) - IF_W'(word_exit);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (flush)           state_d = DRAIN;
        else if (|req_valid) state_d = RUN;
      end
      RUN: begin
        if (flush)                       state_d = DRAIN;
        else if (!hs && inf_q == '0)     state_d = IDLE;
      end
      DRAIN: begin
        if (!flush && inf_q == '0)       state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      inf_q   <= '0;
      vld_q   <= '0;
      data_q  <= '0;
      id_q    <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      inf_q     <= inf_d;
      vld_q[0]  <= hs;
      data_q[0] <= in_data;
      id_q[0]   <= hs ? gnt_idx : '0;
      for (int s = 1; s < LAT; s++) begin
        vld_q[s]  <= vld_q[s-1];
        data_q[s] <= data_q[s-1];
        id_q[s]   <= id_q[s-1];
      end
    end
  end

  // Empty stages carry zero data/id, so the last stage drives the outputs directly.
  assign o_valid = vld_q[LAT-1];
  assign o_data  = data_q[LAT-1];
  assign o_id    = id_q[LAT-1];
  assign busy    = (state_q != IDLE) || (|vld_q);

`ifdef PIPE_SHARE_ARB_STATS_EN
  logic [CNT_W-1:0] cnt_q [N_REQ];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < N_REQ; r++) cnt_q[r] <= '0;
    end else if (hs && (cnt_q[gnt_idx] != {CNT_W{1'b1}})) begin
      cnt_q[gnt_idx] <= cnt_q[gnt_idx] + CNT_W'(1);
    end
  end

  assign stat_count = (int'(stat_sel) < N_REQ) ? cnt_q[stat_sel] : '0;
`endif

endmodule

// File: tb/tb_pipe_share_arb.sv
// Scoreboard bench for pipe_share_arb: independent arbitration/FSM model predicts grants,
// pushes expected words on handshake and pops them as they leave the pipeline.
module tb_pipe_share_arb;
  localparam int N = 4;
  localparam int W = 8;
  localparam int L = 3;
  localparam int S_IDLE = 0, S_RUN = 1, S_DRAIN = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           flush;
  logic [W-1:0]   o_data;
  logic           o_valid;
  logic [1:0]     o_id;
  logic           busy;
`ifdef PIPE_SHARE_ARB_STATS_EN
  logic [1:0]     stat_sel;
  logic [1:0]     stat_count;
`endif

  pipe_share_arb #(.N_REQ(N), .WIDTH(W), .LAT(L), .CNT_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .flush     (flush),
    .o_data    (o_data),
    .o_valid   (o_valid),
    .o_id      (o_id),
`ifdef PIPE_SHARE_ARB_STATS_EN
    .stat_sel  (stat_sel),
    .stat_count(stat_count),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] d;
    logic [1:0]   id;
    int           due;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  int   m_ptr = 0;
  int   m_state = S_IDLE;
  bit   out_now = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic cycle(input logic [N-1:0] v, input logic [N*W-1:0] d, input logic fl);
    int   g, inf, idx, nxt;
    bit   hs;
    exp_t e;
    req_valid = v;
    req_data  = d;
    flush     = fl;
    #1;
    inf = sb.size() + int'(out_now);
    g   = -1;
    if (!fl && m_state != S_DRAIN)
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (g < 0 && v[idx]) g = idx;
      end
    hs = (g >= 0);
    check("req_ready", 32'(req_ready), hs ? (32'd1 << g) : 32'd0);
    if (hs) begin
      e.d = d[g*W +: W];
      e.id = 2'(g);
      e.due = cyc + L;
      sb.push_back(e);
      m_ptr = (g + 1) % N;
    end
    nxt = m_state;
    case (m_state)
      S_IDLE:  nxt = fl ? S_DRAIN : ((|v) ? S_RUN : S_IDLE);
      S_RUN:   nxt = fl ? S_DRAIN : ((!hs && inf == 0) ? S_IDLE : S_RUN);
      default: nxt = (!fl && inf == 0) ? S_IDLE : S_DRAIN;
    endcase
    @(posedge clk);
    cyc++;
    m_state = nxt;
    @(negedge clk);
    out_now = 1'b0;
    if (o_valid) begin
      if (sb.size() == 0) begin
        check("o_valid unexpected", 32'(o_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        out_now = 1'b1;
        check("o_data", 32'(o_data), 32'(e.d));
        check("o_id", 32'(o_id), 32'(e.id));
        check("latency", 32'(cyc), 32'(e.due));
      end
    end else begin
      check("o_data idle", 32'(o_data), 32'd0);
      if (sb.size() > 0 && sb[0].due == cyc) check("o_valid missing", 32'(o_valid), 32'd1);
    end
    check("busy", 32'(busy), 32'(m_state != S_IDLE || (sb.size() + int'(out_now)) > 0));
  endtask

  task automatic do_reset();
    req_valid = '0;
    req_data  = '0;
    flush     = 1'b0;
    rst       = 1'b0;
    #2;
    check("rst o_valid", 32'(o_valid), 32'd0);
    check("rst o_data", 32'(o_data), 32'd0);
    check("rst o_id", 32'(o_id), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst req_ready", 32'(req_ready), 32'd0);
    sb.delete();
    m_ptr   = 0;
    m_state = S_IDLE;
    out_now = 1'b0;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle('0, '0, 1'b0);
  endtask

  function automatic logic [N*W-1:0] rnd_data();
    return {$urandom, $urandom};
  endfunction

  initial begin
`ifdef PIPE_SHARE_ARB_STATS_EN
    stat_sel = '0;
`endif
    @(negedge clk);
    do_reset();
    idle(2);

    // single requester 1 with A5
    cycle(4'b0010, 32'h0000_A500, 1'b0);
    idle(5);

    // all four valid continuously: 0,1,2,3,0,...
    for (int i = 0; i < 8; i++) cycle(4'b1111, rnd_data(), 1'b0);
    idle(5);

    // mixed request patterns
    for (int i = 0; i < 24; i++) cycle(N'($urandom), rnd_data(), 1'b0);
    idle(5);

    // flush with 3 words in flight, requests still offered
    for (int i = 0; i < 3; i++) cycle(4'b1111, rnd_data(), 1'b0);
    for (int i = 0; i < 5; i++) cycle(4'b1111, rnd_data(), 1'b1);
    idle(3);

    // flush while idle-offered, then release with requests pending
    cycle(4'b0100, rnd_data(), 1'b1);
    cycle(4'b0100, rnd_data(), 1'b0);
    idle(5);

    // reset with 2 words in flight; pipeline must come back empty, ptr at 0
    for (int i = 0; i < 2; i++) cycle(4'b1111, rnd_data(), 1'b0);
    do_reset();
    idle(10);
    cycle(4'b1111, rnd_data(), 1'b0);
    idle(5);

`ifdef PIPE_SHARE_ARB_STATS_EN
    do_reset();
    for (int i = 0; i < 5; i++) cycle(4'b0100, rnd_data(), 1'b0);
    idle(4);
    for (int s = 0; s < N; s++) begin
      stat_sel = 2'(s);
      #1;
      check($sformatf("stat_count[%0d]", s), 32'(stat_count), (s == 2) ? 32'd3 : 32'd0);
    end
`endif

    check("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/pipe_share_arb.md
PIPE_SHARE_ARB -- requirements
Module: pipe_share_arb

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, number of requesters sharing the pipeline (1..8).
REQ-002 The block SHALL have parameter WIDTH, default 8, data width per requester.
REQ-003 The block SHALL have parameter LAT, default 3, pipeline depth in stages (>=1).
REQ-004 The block SHALL have parameter CNT_W, default 16, width of statistics counters.
REQ-005 clk  input  1  clock; all state changes on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 req_valid  input  N_REQ  per-requester word-offered flag.
REQ-008 req_data  input  N_REQ*WIDTH  requester i data in bits [i*WIDTH +: WIDTH].
REQ-009 req_ready  output  N_REQ  one-hot-or-zero grant; handshake when req_valid[i] & req_ready[i].
REQ-010 flush  input  1  stop accepting and drain in-flight words.
REQ-011 o_data  output  WIDTH  data leaving last stage.
REQ-012 o_valid  output  1  o_data holds an accepted word this cycle.
REQ-013 o_id  output  max(1,$clog2(N_REQ))  index of requester that issued o_data.
REQ-014 busy  output  1  high when state != IDLE or any stage holds a valid word.

Function
REQ-015 The block SHALL grant at most one requester per cycle; req_ready[i] SHALL be combinational from req_valid, state and round-robin pointer and SHALL be high only if req_valid[i] is high.
REQ-016 Arbitration SHALL be round-robin: search starts at pointer ptr, first valid index in order ptr, ptr+1, ... wraps modulo N_REQ.
REQ-017 After a grant to i, ptr SHALL become (i+1) mod N_REQ; with no grant ptr SHALL hold.
REQ-018 An accepted word SHALL enter stage 0 with its requester index and a valid bit; every stage SHALL shift one per cycle, no stalls.
REQ-019 o_valid/o_data/o_id SHALL present the word exactly LAT cycles after the handshake cycle (handshake at edge k -> visible after edge k+LAT).
REQ-020 Stages without an accepted word SHALL carry valid=0; o_data SHALL be 0 when o_valid is 0.
REQ-021 States: IDLE, RUN, DRAIN.
REQ-022 IDLE -> RUN when any req_valid is high and flush low; grants are issued in IDLE and RUN.
REQ-023 RUN -> IDLE when no handshake occurs and in-flight count is 0.
REQ-024 Any state -> DRAIN when flush high; no grants while in DRAIN or while flush is high.
REQ-025 DRAIN -> IDLE when flush low and in-flight count 0; flush held high keeps DRAIN indefinitely.
REQ-026 In-flight count (width $clog2(LAT+1)) SHALL track valid stages: +1 on handshake, -1 on word exit, unchanged when both occur same cycle; never exceeds LAT.
REQ-027 With N_REQ=1, ptr SHALL be constant 0 and o_id constant 0.

Reset
REQ-028 On rst low, immediately and regardless of clk: all stage valid bits and data 0, ptr 0, state IDLE, in-flight 0, statistics counters 0.
REQ-029 Outputs during and after reset until first handshake exits: o_valid 0, o_data 0, o_id 0, busy 0, req_ready 0.
REQ-030 Reset asserted mid-operation SHALL discard all in-flight words; none SHALL appear on o_valid after reset release.

Configuration
REQ-031 Macro PIPE_SHARE_ARB_STATS_EN defined: block SHALL add input stat_sel (max(1,$clog2(N_REQ)) bits) and output stat_count (CNT_W bits), a saturating per-requester grant counter read combinationally by stat_sel; counters saturate at 2^CNT_W-1.
REQ-032 Macro PIPE_SHARE_ARB_STATS_EN undefined: stat ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-033 Single requester: req_valid=4'b0010, req_data[15:8]=8'hA5 one cycle -> o_valid=1, o_data=8'hA5, o_id=1 exactly 3 cycles later, one cycle only.
REQ-034 All four valid continuously from ptr=0 -> grants 0,1,2,3,0,... ; o_id sequence 0,1,2,3,0 starting 3 cycles after first grant, o_valid continuous.
REQ-035 Flush with 3 words in flight -> req_ready 0 from flush cycle, all 3 words still exit in order, busy falls after last exit, state IDLE once flush low.
REQ-036 rst low with 2 words in flight, release 1 cycle later -> o_valid stays 0 for next 10 cycles, ptr=0, busy=0.
REQ-037 With PIPE_SHARE_ARB_STATS_EN, CNT_W=2, requester 2 granted 5 times -> stat_sel=2 reads 3; other indices read 0.
